// File: rtl/if_id_latch_pkg.sv
// ----------------------------------------------------------------------------
// if_id_latch_pkg
//   Shared types and constants for the IF/ID pipeline latch.
//   - PC_W / INSTR_W / NOP_WORD : beat field widths and the bubble filler word
//   - ifid_state_t              : occupancy state {EMPTY, ONE, TWO}
//   - ifid_beat_t               : one captured fetch beat {pc, instr, bubble}
//   - idle_beat()               : beat value held in a slot after reset
// ----------------------------------------------------------------------------
package if_id_latch_pkg;

   localparam int              PC_W     = 7;
   localparam int              INSTR_W  = 32;
   localparam logic [31:0]     NOP_WORD = 32'h0000_0000;

   // Encodings are explicit so the state register stays a plain 2-bit vector.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } ifid_state_t;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               bubble;
   } ifid_beat_t;

   function automatic ifid_beat_t idle_beat();
      ifid_beat_t b;
      b.pc     = '0;
      b.instr  = NOP_WORD;
      b.bubble = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/if_id_latch_if.sv
// ----------------------------------------------------------------------------
// if_id_latch_if
//   Fetch-side and decode-side handshake bundle of the IF/ID latch.
//   Fetch : in_valid, in_ready, pc_in, instr_in, bubble_in
//   Decode: out_valid, out_ready, pc_out, instr_out, out_bubble
//   modport slave  - the latch itself
//   modport master - the surrounding fetch/decode logic (or a bench)
// ----------------------------------------------------------------------------
interface if_id_latch_if;
   import if_id_latch_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [PC_W-1:0]    pc_in;
   logic [INSTR_W-1:0] instr_in;
   logic               bubble_in;

   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    pc_out;
   logic [INSTR_W-1:0] instr_out;
   logic               out_bubble;

   modport slave (
      input  in_valid, pc_in, instr_in, bubble_in, out_ready,
      output in_ready, out_valid, pc_out, instr_out, out_bubble
   );

   modport master (
      output in_valid, pc_in, instr_in, bubble_in, out_ready,
      input  in_ready, out_valid, pc_out, instr_out, out_bubble
   );
endinterface

// File: rtl/if_id_latch_slot.sv
// ----------------------------------------------------------------------------
// if_id_slot
//   Load-enabled register holding one ifid_beat_t. Used for both the main
//   (head) slot and the skid slot of the IF/ID latch.
//   clk    : clock, posedge
//   rst    : synchronous active-high reset, clears to idle_beat()
//   load_i : capture beat_i on this edge
//   beat_i : beat to capture
//   beat_o : held beat
// ----------------------------------------------------------------------------
module if_id_slot
   import if_id_latch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  ifid_beat_t beat_i,
   output ifid_beat_t beat_o
);

   ifid_beat_t beat_q;
   ifid_beat_t beat_d;

   always_comb begin
      beat_d = beat_q;
      if (load_i) beat_d = beat_i;
   end

   always_ff @(posedge clk) begin
      if (rst) beat_q <= idle_beat();
      else     beat_q <= beat_d;
   end

   assign beat_o = beat_q;

endmodule

// File: rtl/if_id_latch.sv
// ----------------------------------------------------------------------------
// if_id_latch
//   IF/ID pipeline register with a one-entry skid. Captures {pc, instr} per
//   accepted fetch beat, replaces bubble beats by NOP_WORD, and holds up to two
//   beats so decode stalls never lose a fetched word. A taken-branch flush
//   empties it. All outputs come straight from flops.
//
//   clk        : clock, posedge
//   rst        : synchronous active-high reset (beats flush and all inputs)
//   flush      : discard held beats; also drops a simultaneous incoming beat
//   bus        : if_id_latch_if.slave (fetch + decode handshakes)
//   stall_cnt  : cycles with out_valid & !out_ready, saturating  (PERF_CNT_EN)
//   bubble_cnt : accepted bubble beats, saturating                (PERF_CNT_EN)
//
//   Build option: define PERF_CNT_EN to add the two perf counters (width
//   CNT_W). Without it the counters and their ports do not exist.
// ----------------------------------------------------------------------------
module if_id_latch
   import if_id_latch_pkg::*;
`ifdef PERF_CNT_EN
#(
   parameter int CNT_W = 16
)
`endif
(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   if_id_latch_if.slave       bus
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   bubble_cnt
`endif
);

   localparam logic [1:0] ST_EMPTY = EMPTY;
   localparam logic [1:0] ST_ONE   = ONE;
   localparam logic [1:0] ST_TWO   = TWO;

   logic [1:0] state_q, state_d;
   logic       out_valid_q;
   logic       in_ready_q;

   logic       accept;
   logic       pop;
   logic       main_ld;
   logic       skid_ld;
   logic       main_from_skid;

   ifid_beat_t in_beat;
   ifid_beat_t main_d;
   ifid_beat_t main_q;
   ifid_beat_t skid_q;

   assign accept = bus.in_valid & in_ready_q;
   assign pop    = out_valid_q & bus.out_ready;

   // pc passes through untouched; only the instruction word is replaced.
   always_comb begin
      in_beat.pc     = bus.pc_in;
      in_beat.instr  = bus.bubble_in ? NOP_WORD : bus.instr_in;
      in_beat.bubble = bus.bubble_in;
   end

   // Occupancy control. flush wins over accept and pop; slots are not
   // loaded on flush so the head fields keep their last value.
   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      skid_ld        = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  main_ld = 1'b1;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  main_ld = 1'b1;
               end else if (accept) begin
                  skid_ld = 1'b1;
                  state_d = ST_TWO;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  main_ld        = 1'b1;
                  main_from_skid = 1'b1;
                  state_d        = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign main_d = main_from_skid ? skid_q : in_beat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         // Handshake flags are decoded from the next state so that they are
         // registered and in_ready never sees out_ready combinationally.
         out_valid_q <= (state_d != ST_EMPTY);
         in_ready_q  <= (state_d != ST_TWO);
      end
   end

   if_id_slot u_main (
      .clk    (clk),
      .rst    (rst),
      .load_i (main_ld),
      .beat_i (main_d),
      .beat_o (main_q)
   );

   if_id_slot u_skid (
      .clk    (clk),
      .rst    (rst),
      .load_i (skid_ld),
      .beat_i (in_beat),
      .beat_o (skid_q)
   );

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.pc_out     = main_q.pc;
   assign bus.instr_out  = main_q.instr;
   assign bus.out_bubble = main_q.bubble;

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Saturating counters; flush deliberately leaves them alone.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (out_valid_q && !bus.out_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (accept && bus.bubble_in && (bubble_cnt_q != '1))
         bubble_cnt_d = bubble_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_latch.sv
// ----------------------------------------------------------------------------
// tb_if_id_latch
//   Directed bench for if_id_latch. Accepted beats are pushed to a scoreboard
//   queue; popped beats are compared against its head. Direct checks cover
//   reset values, handshake flags, bubble substitution, flush and reset.
//   With PERF_CNT_EN defined the counters are built 3 bits wide so that
//   saturation is reachable in a few cycles.
// ----------------------------------------------------------------------------
module tb_if_id_latch;
   import if_id_latch_pkg::*;

`ifdef PERF_CNT_EN
   localparam int CW = 3;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] bubble_cnt;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;

   if_id_latch_if bif ();

`ifdef PERF_CNT_EN
   if_id_latch #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .bus        (bif),
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
   );
`else
   if_id_latch dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bif)
   );
`endif

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   ifid_beat_t sb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bookkeeping for the edge about to happen, then advance one cycle and
   // settle 1 time unit past the edge.
   task automatic tick();
      ifid_beat_t e;
      ifid_beat_t n;
      if (rst || flush) begin
         sb.delete();
      end else begin
         if (bif.out_valid && bif.out_ready) begin
            chk("sb_avail", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("pop_pc",     64'(bif.pc_out),     64'(e.pc));
               chk("pop_instr",  64'(bif.instr_out),  64'(e.instr));
               chk("pop_bubble", 64'(bif.out_bubble), 64'(e.bubble));
            end
         end
         if (bif.in_valid && bif.in_ready) begin
            n.pc     = bif.pc_in;
            n.instr  = bif.bubble_in ? NOP_WORD : bif.instr_in;
            n.bubble = bif.bubble_in;
            sb.push_back(n);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [PC_W-1:0] pc,
                        input logic [INSTR_W-1:0] ins, input logic bub);
      bif.in_valid  = v;
      bif.pc_in     = pc;
      bif.instr_in  = ins;
      bif.bubble_in = bub;
   endtask

   initial begin
      drive(1'b0, '0, '0, 1'b0);
      bif.out_ready = 1'b0;

      // Reset
      rst = 1'b1;
      tick(); tick();
      chk("rst_out_valid",  64'(bif.out_valid),  64'd0);
      chk("rst_in_ready",   64'(bif.in_ready),   64'd1);
      chk("rst_instr",      64'(bif.instr_out),  64'd0);
      chk("rst_pc",         64'(bif.pc_out),     64'd0);
      chk("rst_bubble",     64'(bif.out_bubble), 64'd0);
      rst = 1'b0;

`ifdef PERF_CNT_EN
      // Counters: 4 stalls, 2 bubbles, flush keeps them, then saturation
      chk("cnt_rst_stall",  64'(stall_cnt),  64'd0);
      chk("cnt_rst_bubble", 64'(bubble_cnt), 64'd0);
      bif.out_ready = 1'b0;
      drive(1'b1, 7'd1, 32'hAAAA_0001, 1'b1); tick();
      drive(1'b1, 7'd2, 32'hAAAA_0002, 1'b1); tick();
      drive(1'b0, '0, '0, 1'b0);
      tick(); tick(); tick();
      chk("cnt_stall4",  64'(stall_cnt),  64'd4);
      chk("cnt_bubble2", 64'(bubble_cnt), 64'd2);
      bif.out_ready = 1'b1;
      flush = 1'b1; tick(); flush = 1'b0;
      chk("cnt_flush_stall",  64'(stall_cnt),  64'd4);
      chk("cnt_flush_bubble", 64'(bubble_cnt), 64'd2);
      bif.out_ready = 1'b0;
      drive(1'b1, 7'd3, 32'h0000_0003, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b0);
      repeat (6) tick();
      chk("cnt_stall_sat", 64'(stall_cnt), 64'd7);
      bif.out_ready = 1'b1;
      tick();
      chk("cnt_drained", 64'(bif.out_valid), 64'd0);
`endif

      // Streaming, back-to-back, decode always ready
      bif.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 7'(i), 32'h1000_0000 | 32'(i), 1'b0);
         tick();
         chk("stream_in_ready",  64'(bif.in_ready),  64'd1);
         chk("stream_out_valid", 64'(bif.out_valid), 64'd1);
         chk("stream_pc",        64'(bif.pc_out),    64'(i));
      end
      drive(1'b0, '0, '0, 1'b0); tick();
      chk("stream_idle", 64'(bif.out_valid), 64'd0);

      // Back-pressure fills the skid
      bif.out_ready = 1'b0;
      drive(1'b1, 7'd3, 32'h3333_3333, 1'b0); tick();
      chk("bp_one_in_ready", 64'(bif.in_ready), 64'd1);
      drive(1'b1, 7'd4, 32'h4444_4444, 1'b0); tick();
      chk("bp_two_in_ready", 64'(bif.in_ready), 64'd0);
      drive(1'b0, '0, '0, 1'b0); tick();
      chk("bp_head_stable", 64'(bif.pc_out),    64'd3);
      chk("bp_instr_stable", 64'(bif.instr_out), 64'h3333_3333);
      bif.out_ready = 1'b1;
      tick();
      chk("bp_skid_to_main", 64'(bif.pc_out),   64'd4);
      chk("bp_ready_again",  64'(bif.in_ready), 64'd1);
      tick();
      chk("bp_empty", 64'(bif.out_valid), 64'd0);

      // Bubble beat
      drive(1'b1, 7'd7, 32'hDEAD_BEEF, 1'b1); tick();
      chk("bub_instr", 64'(bif.instr_out),  64'(NOP_WORD));
      chk("bub_flag",  64'(bif.out_bubble), 64'd1);
      chk("bub_pc",    64'(bif.pc_out),     64'd7);
      drive(1'b0, '0, '0, 1'b0); tick();

      // Flush while full, with fetch valid and decode ready
      bif.out_ready = 1'b0;
      drive(1'b1, 7'd10, 32'h0A0A_0A0A, 1'b0); tick();
      drive(1'b1, 7'd11, 32'h0B0B_0B0B, 1'b0); tick();
      bif.out_ready = 1'b1;
      drive(1'b1, 7'd12, 32'h0C0C_0C0C, 1'b0);
      flush = 1'b1; tick(); flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      chk("flush2_out_valid", 64'(bif.out_valid), 64'd0);
      chk("flush2_in_ready",  64'(bif.in_ready),  64'd1);
      chk("flush2_head_hold", 64'(bif.pc_out),    64'd10);

      // Flush together with an accept while holding one beat
      bif.out_ready = 1'b0;
      drive(1'b1, 7'd13, 32'h0D0D_0D0D, 1'b0); tick();
      drive(1'b1, 7'd14, 32'h0E0E_0E0E, 1'b0);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("flush1_out_valid", 64'(bif.out_valid), 64'd0);
      chk("flush1_in_ready",  64'(bif.in_ready),  64'd1);
      chk("flush1_head_hold", 64'(bif.pc_out),    64'd13);
      bif.out_ready = 1'b1;
      drive(1'b1, 7'd20, 32'h2020_2020, 1'b0); tick();
      chk("post_flush_pc", 64'(bif.pc_out), 64'd20);
      drive(1'b0, '0, '0, 1'b0); tick();
      chk("post_flush_idle", 64'(bif.out_valid), 64'd0);

      // Reset in the middle of a full latch
      bif.out_ready = 1'b0;
      drive(1'b1, 7'd30, 32'h3030_3030, 1'b0); tick();
      drive(1'b1, 7'd31, 32'h3131_3131, 1'b0); tick();
      drive(1'b0, '0, '0, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_out_valid", 64'(bif.out_valid), 64'd0);
      chk("midrst_in_ready",  64'(bif.in_ready),  64'd1);
      chk("midrst_pc",        64'(bif.pc_out),    64'd0);
      bif.out_ready = 1'b1;
      drive(1'b1, 7'd40, 32'h4040_4040, 1'b0); tick();
      chk("midrst_next_pc", 64'(bif.pc_out), 64'd40);
      drive(1'b0, '0, '0, 1'b0); tick();

      chk("sb_empty_end", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
